// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes, beat size and
// read-slave FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_8B     = 3'b011;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    // WRAP bursts are legal only for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts of 8-byte beats.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        burst,
    input  logic [7:0]        len,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    // Container size for a legal WRAP is (len+1)*8, so its mask is {len, 3'b111}.
    always_comb begin
        incr_addr = addr + ADDR_W'(8);
        wrap_mask = ADDR_W'({len, 3'b111});
        next_addr = addr;
        case (burst)
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI read-channel slave: one outstanding AR, register-array memory with a
// backdoor write port, RLAST-terminated R bursts with per-beat RRESP.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 64,
    parameter int DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [ID_W-1:0]   RID,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [63:0]       i_wr_data
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];

    rd_state_t         state_q, state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic [7:0]        beat_q, beat_d;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_err;
    logic              fetch_ok;
    logic [63:0]       fetch_data;
    logic [1:0]        fetch_resp;
    logic              ar_err;
    logic              wr_in_range;
    logic              unused_wr_lsb;

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign unused_wr_lsb = ^i_wr_addr[2:0];

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .burst     (burst_q),
        .len       (len_q),
        .next_addr (next_addr)
    );

    // Whole-burst error classification of the incoming request.
    always_comb begin
        ar_err = (ARSIZE != SIZE_8B) || (ARBURST == BURST_RSVD) ||
                 ((ARBURST == WRAP) && !wrap_len_ok(ARLEN));
    end

    // Beat fetch: beat 0 comes straight from the AR channel, later beats from
    // the address generator; out-of-range or erroneous beats return zero/SLVERR.
    always_comb begin
        fetch_addr = (state_q == IDLE) ? ARADDR : next_addr;
        fetch_err  = (state_q == IDLE) ? ar_err : err_q;
        fetch_ok   = !fetch_err && ((fetch_addr[ADDR_W-1:3] >> AW) == '0);
        fetch_data = fetch_ok ? mem[fetch_addr[AW+2:3]] : '0;
        fetch_resp = fetch_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        beat_d    = beat_q;
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    state_d   = BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    burst_d   = ARBURST;
                    err_d     = ar_err;
                    beat_d    = '0;
                    rlast_d   = (ARLEN == 8'd0);
                    rdata_d   = fetch_data;
                    rresp_d   = fetch_resp;
                end
            end
            BURST: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 8'd1;
                        rlast_d = ((beat_q + 8'd1) == len_q);
                        rdata_d = fetch_data;
                        rresp_d = fetch_resp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
        end
    end

    assign wr_in_range = ((i_wr_addr[ADDR_W-1:3] >> AW) == '0);

    // Backdoor write port; memory is not affected by reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && wr_in_range) begin
            mem[i_wr_addr[AW+2:3]] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed self-checking bench for axi_rd_slave.
module tb_axi_rd_slave;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID;
    logic        RREADY;
    logic [63:0] RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        i_wr_en;
    logic [31:0] i_wr_addr;
    logic [63:0] i_wr_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_d [16];
    logic [1:0]  exp_r [16];

    axi_rd_slave #(.ADDR_W(32), .ID_W(64), .DEPTH(256)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [63:0] data);
        @(negedge i_clk);
        i_wr_en   = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        @(posedge i_clk);
        #1 i_wr_en = 1'b0;
    endtask

    // Presents an AR and returns at the negedge after the handshake.
    task automatic issue_ar(input logic [63:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int t;
        @(negedge i_clk);
        ARVALID = 1'b1;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        t = 0;
        while (!ARREADY && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        check("arready_wait", {63'b0, ARREADY}, 64'd1);
        @(posedge i_clk);
        #1 ARVALID = 1'b0;
        @(negedge i_clk);
        check("arready_drop", {63'b0, ARREADY}, 64'd0);
        check("rvalid_rise", {63'b0, RVALID}, 64'd1);
    endtask

    // Runs a full burst; mode 1 drives RREADY 1,0,0,1,0,0,...
    task automatic run_burst(input logic [63:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int mode);
        int          n;
        int          k;
        int          c;
        logic        held;
        logic [63:0] hold_d;
        logic        hold_l;
        n    = int'(len) + 1;
        k    = 0;
        c    = 0;
        held = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        RREADY = 1'b1;
        issue_ar(id, addr, len, size, burst);
        while (k < n && c < 200) begin
            RREADY = (mode == 1) ? ((c % 3) == 0) : 1'b1;
            if (held) begin
                check("hold_rdata", RDATA, hold_d);
                check("hold_rlast", {63'b0, RLAST}, {63'b0, hold_l});
                held = 1'b0;
            end
            if (RVALID) begin
                if (RREADY) begin
                    check($sformatf("rdata_b%0d", k), RDATA, exp_d[k]);
                    check($sformatf("rresp_b%0d", k), {62'b0, RRESP}, {62'b0, exp_r[k]});
                    check($sformatf("rid_b%0d", k), RID, id);
                    check($sformatf("rlast_b%0d", k), {63'b0, RLAST}, {63'b0, (k == n - 1)});
                    k++;
                end else begin
                    held   = 1'b1;
                    hold_d = RDATA;
                    hold_l = RLAST;
                end
            end
            @(negedge i_clk);
            c++;
        end
        check("beat_count", 64'(k), 64'(n));
        check("arready_back", {63'b0, ARREADY}, 64'd1);
        check("rvalid_low", {63'b0, RVALID}, 64'd0);
        RREADY = 1'b0;
    endtask

    initial begin
        i_rst     = 1'b1;
        ARVALID   = 1'b0;
        ARID      = '0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = 3'b011;
        ARBURST   = 2'b01;
        RREADY    = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_arready", {63'b0, ARREADY}, 64'd0);
        check("rst_rvalid", {63'b0, RVALID}, 64'd0);
        check("rst_rlast", {63'b0, RLAST}, 64'd0);
        check("rst_rid", RID, 64'd0);
        check("rst_rdata", RDATA, 64'd0);
        check("rst_rresp", {62'b0, RRESP}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("arready_after_rst", {63'b0, ARREADY}, 64'd1);

        // Preload
        preload(32'h00, 64'd1);
        preload(32'h08, 64'd2);
        preload(32'h10, 64'd3);
        preload(32'h18, 64'd4);
        preload(32'h20, 64'd10);
        preload(32'h28, 64'd11);
        preload(32'h30, 64'd12);
        preload(32'h38, 64'd13);
        preload(32'h48, 64'hAA);
        preload(32'h7F0, 64'h55);
        preload(32'h7F8, 64'h66);

        // 1. INCR, 4 beats, full throughput
        exp_d[0] = 64'd1; exp_d[1] = 64'd2; exp_d[2] = 64'd3; exp_d[3] = 64'd4;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
        run_burst(64'h5, 32'h0, 8'd3, 3'b011, 2'b01, 0);

        // 2. Same burst with backpressure
        run_burst(64'h5, 32'h0, 8'd3, 3'b011, 2'b01, 1);

        // 3. WRAP from word 6 inside a 32-byte container
        exp_d[0] = 64'd12; exp_d[1] = 64'd13; exp_d[2] = 64'd10; exp_d[3] = 64'd11;
        run_burst(64'h7, 32'h30, 8'd3, 3'b011, 2'b10, 0);

        // 4a. Unsupported size: whole burst SLVERR
        exp_d[0] = 64'd0; exp_d[1] = 64'd0;
        exp_r[0] = 2'b10; exp_r[1] = 2'b10;
        run_burst(64'h9, 32'h0, 8'd1, 3'b010, 2'b01, 0);

        // 4b. INCR crossing the end of memory
        exp_d[0] = 64'h55; exp_d[1] = 64'h66; exp_d[2] = 64'd0; exp_d[3] = 64'd0;
        exp_r[0] = 2'b00;  exp_r[1] = 2'b00;  exp_r[2] = 2'b10; exp_r[3] = 2'b10;
        run_burst(64'hA, 32'h7F0, 8'd3, 3'b011, 2'b01, 0);

        // 4c. Reserved burst type, single beat
        exp_d[0] = 64'd0; exp_r[0] = 2'b10;
        run_burst(64'hB, 32'h0, 8'd0, 3'b011, 2'b11, 0);

        // 5. FIXED, three beats of the same word
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 64'hAA;
            exp_r[i] = 2'b00;
        end
        run_burst(64'hC, 32'h48, 8'd2, 3'b011, 2'b00, 0);

        // 6. Reset during beat 2 of an 8-beat burst
        RREADY = 1'b1;
        issue_ar(64'hD, 32'h0, 8'd7, 3'b011, 2'b01);
        check("rb_beat0", RDATA, 64'd1);
        @(negedge i_clk);
        check("rb_beat1", RDATA, 64'd2);
        @(negedge i_clk);
        check("rb_beat2", RDATA, 64'd3);
        i_rst  = 1'b1;
        RREADY = 1'b0;
        @(negedge i_clk);
        check("midrst_rvalid", {63'b0, RVALID}, 64'd0);
        check("midrst_arready", {63'b0, ARREADY}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("postrst_arready", {63'b0, ARREADY}, 64'd1);
        check("postrst_rvalid", {63'b0, RVALID}, 64'd0);
        @(negedge i_clk);
        check("postrst_no_beat", {63'b0, RVALID}, 64'd0);
        exp_d[0] = 64'd1; exp_d[1] = 64'd2; exp_d[2] = 64'd3; exp_d[3] = 64'd4;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
        run_burst(64'hE, 32'h0, 8'd3, 3'b011, 2'b01, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
